// File: rtl/conv_window_gen.sv
// conv_window_gen: streaming sliding-window generator feeding the
// convolution core. Buffers the last FILTER_SIZE rows of a raster-order
// 8-bit pixel stream and emits one FILTER_SIZE x FILTER_SIZE window per
// valid position, stalling the stream until the core consumes it.
//
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   pix_in, pix_valid   raster-order pixel stream (unsigned 8-bit)
//   pix_ready           pixel accepted this cycle when high with pix_valid
//   window_out          flattened window, element (i,j) at
//                       [(i*FILTER_SIZE+j)*8 +: 8], i=0 oldest row
//   window_valid        one-cycle pulse, drives the core's mult_en
//   shift_buffer        one-cycle pulse from the core: window consumed
//   frame_done          one-cycle pulse after the last window is consumed
//   win_row, win_col    top-left window coordinate, only when the macro
//                       CONV_WINDOW_GEN_POS_EN is defined
module conv_window_gen #(
    parameter int IMAGE_WIDTH  = 128,
    parameter int IMAGE_HEIGHT = 128,
    parameter int FILTER_SIZE  = 3,
    parameter int OUT          = IMAGE_HEIGHT - FILTER_SIZE + 1
`ifdef CONV_WINDOW_GEN_POS_EN
    ,
    localparam int OUT_C   = IMAGE_WIDTH - FILTER_SIZE + 1,
    localparam int OUT_MAX = (OUT > OUT_C) ? OUT : OUT_C,
    localparam int POS_W   = (OUT_MAX > 1) ? $clog2(OUT_MAX) : 1
`endif
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [7:0]                          pix_in,
    input  logic                                pix_valid,
    output logic                                pix_ready,
    output logic [FILTER_SIZE*FILTER_SIZE*8-1:0] window_out,
    output logic                                window_valid,
    input  logic                                shift_buffer,
    output logic                                frame_done
`ifdef CONV_WINDOW_GEN_POS_EN
    ,
    output logic [POS_W-1:0]                    win_row,
    output logic [POS_W-1:0]                    win_col
`endif
);

    localparam int COL_W  = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
    localparam int ROW_W  = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
    localparam int SLOT_W = $clog2(FILTER_SIZE);

    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(IMAGE_WIDTH - 1);
    // Last image row: the row whose windows sit at output row OUT-1.
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(OUT + FILTER_SIZE - 2);
    localparam logic [COL_W-1:0]  COL_EDGE  = COL_W'(FILTER_SIZE - 1);
    localparam logic [ROW_W-1:0]  ROW_EDGE  = ROW_W'(FILTER_SIZE - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(FILTER_SIZE - 1);

    typedef enum logic [1:0] {
        S_FILL,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t             state_q, state_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [SLOT_W-1:0]  slot_q, slot_d;
    logic               last_q, last_d;
    logic               done_q, done_d;

    logic [7:0] win_q [FILTER_SIZE][FILTER_SIZE];
    logic [7:0] win_d [FILTER_SIZE][FILTER_SIZE];

    logic [7:0] line_q [FILTER_SIZE][IMAGE_WIDTH];

    logic [7:0] new_col [FILTER_SIZE];
    logic       accept;
    logic       valid_pos;

`ifdef CONV_WINDOW_GEN_POS_EN
    logic [POS_W-1:0] win_row_q, win_row_d;
    logic [POS_W-1:0] win_col_q, win_col_d;
`endif

    // Row buffer slot holding image row (current row + k) mod FILTER_SIZE.
    function automatic logic [SLOT_W-1:0] slot_add(
        input logic [SLOT_W-1:0] s,
        input int                k
    );
        int t;
        t = int'(s) + k;
        if (t >= FILTER_SIZE) begin
            t = t - FILTER_SIZE;
        end
        return SLOT_W'(t);
    endfunction

    assign pix_ready    = rst && (state_q == S_FILL);
    assign window_valid = (state_q == S_ISSUE);
    assign frame_done   = done_q;
    assign accept       = pix_valid && pix_ready;
    assign valid_pos    = (row_q >= ROW_EDGE) && (col_q >= COL_EDGE);

    // Right-hand column of the next window: older rows come from the
    // row buffers, the newest row is the incoming pixel itself.
    always_comb begin
        for (int i = 0; i < FILTER_SIZE; i++) begin
            new_col[i] = '0;
        end
        for (int i = 0; i < FILTER_SIZE - 1; i++) begin
            new_col[i] = line_q[slot_add(slot_q, i + 1)][col_q];
        end
        new_col[FILTER_SIZE-1] = pix_in;
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        slot_d  = slot_q;
        last_d  = last_q;
        done_d  = 1'b0;
        win_d   = win_q;
`ifdef CONV_WINDOW_GEN_POS_EN
        win_row_d = win_row_q;
        win_col_d = win_col_q;
`endif

        unique case (state_q)
            S_FILL: begin
                if (accept) begin
                    for (int i = 0; i < FILTER_SIZE; i++) begin
                        for (int j = 0; j < FILTER_SIZE - 1; j++) begin
                            win_d[i][j] = win_q[i][j+1];
                        end
                        win_d[i][FILTER_SIZE-1] = new_col[i];
                    end

                    last_d = (row_q == ROW_LAST) && (col_q == COL_LAST);

                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        if (row_q == ROW_LAST) begin
                            row_d  = '0;
                            slot_d = '0;
                        end else begin
                            row_d  = row_q + 1'b1;
                            slot_d = (slot_q == SLOT_LAST) ? '0
                                                           : slot_q + 1'b1;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end

                    if (valid_pos) begin
                        state_d = S_ISSUE;
`ifdef CONV_WINDOW_GEN_POS_EN
                        win_row_d = POS_W'(row_q - ROW_EDGE);
                        win_col_d = POS_W'(col_q - COL_EDGE);
`endif
                    end
                end
            end

            S_ISSUE: begin
                state_d = S_WAIT;
            end

            S_WAIT: begin
                if (shift_buffer) begin
                    state_d = S_FILL;
                    if (last_q) begin
                        // Counters already wrapped on the final accept;
                        // clearing again keeps the frame restart explicit.
                        done_d = 1'b1;
                        last_d = 1'b0;
                        col_d  = '0;
                        row_d  = '0;
                        slot_d = '0;
                    end
                end
            end

            default: begin
                state_d = S_FILL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_FILL;
            col_q   <= '0;
            row_q   <= '0;
            slot_q  <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < FILTER_SIZE; i++) begin
                for (int j = 0; j < FILTER_SIZE; j++) begin
                    win_q[i][j] <= '0;
                end
            end
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            slot_q  <= slot_d;
            last_q  <= last_d;
            done_q  <= done_d;
            win_q   <= win_d;
        end
    end

    // Row buffers carry no reset: stale rows are never part of an issued
    // window because issue starts only once FILTER_SIZE rows are rewritten.
    always_ff @(posedge clk) begin
        if (accept) begin
            line_q[slot_q][col_q] <= pix_in;
        end
    end

    always_comb begin
        window_out = '0;
        for (int i = 0; i < FILTER_SIZE; i++) begin
            for (int j = 0; j < FILTER_SIZE; j++) begin
                window_out[(i*FILTER_SIZE+j)*8 +: 8] = win_q[i][j];
            end
        end
    end

`ifdef CONV_WINDOW_GEN_POS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win_row_q <= '0;
            win_col_q <= '0;
        end else begin
            win_row_q <= win_row_d;
            win_col_q <= win_col_d;
        end
    end

    assign win_row = win_row_q;
    assign win_col = win_col_q;
`endif

endmodule
